regfile_write_arbiter: RTL and testbench

Write-side front end for the shared dual-bank (A/B) register file used by both cores. The block accepts register write requests from core 1 and core 2 over valid/ready handshakes and buffers each core's requests in its own FIFO. Per bank, it arbitrates round-robin between the two FIFO heads and drives one registered, single-cycle write pulse per bank per cycle into the register file write ports.

---
 rtl/regfile_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-side front end for the shared dual-bank register file: one FIFO per
// core, round-robin arbitration per bank, registered write strobes per bank.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    c1_req_valid,
  output logic                    c1_req_ready,
  input  logic                    c1_req_bank,
  input  logic [AW-1:0]           c1_req_addr,
  input  logic [DW-1:0]           c1_req_data,
  input  logic                    c2_req_valid,
  output logic                    c2_req_ready,
  input  logic                    c2_req_bank,
  input  logic [AW-1:0]           c2_req_addr,
  input  logic [DW-1:0]           c2_req_data,
  output logic                    wr_en_A,
  output logic [AW-1:0]           wr_addr_A,
  output logic [DW-1:0]           wr_data_A,
  output logic                    wr_en_B,
  output logic [AW-1:0]           wr_addr_B,
  output logic [DW-1:0]           wr_data_B,
  output logic [$clog2(DEPTH):0]  c1_level,
  output logic [$clog2(DEPTH):0]  c2_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  // Index 0 is core 1, index 1 is core 2 throughout.
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0]          cand_a;
  logic [1:0]          cand_b;
  logic [1:0]          gnt_a;
  logic [1:0]          gnt_b;
  entry_t [1:0]        req_entry;
  entry_t [1:0]        head;
  logic [1:0][LW-1:0]  level;
  entry_t              win_a;
  entry_t              win_b;
  logic                rr_a;   // 0 = core 1 wins next contended bank A grant
  logic                rr_b;   // 0 = core 1 wins next contended bank B grant

  assign req_valid    = {c2_req_valid, c1_req_valid};
  assign req_entry[0] = {c1_req_bank, c1_req_addr, c1_req_data};
  assign req_entry[1] = {c2_req_bank, c2_req_addr, c2_req_data};
  assign c1_req_ready = req_ready[0];
  assign c2_req_ready = req_ready[1];
  assign c1_level     = level[0];
  assign c2_level     = level[1];

  for (genvar n = 0; n < 2; n++) begin : g_core
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   cnt;
    logic            nonempty;

    assign nonempty     = (cnt != '0);
    assign req_ready[n] = !rst && (cnt != LW'(DEPTH));
    assign push[n]      = req_valid[n] && req_ready[n];
    assign head[n]      = mem[rd_ptr];
    assign level[n]     = cnt;
    assign cand_a[n]    = nonempty && !mem[rd_ptr].bank;
    assign cand_b[n]    = nonempty &&  mem[rd_ptr].bank;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[n]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[n])  rd_ptr <= rd_ptr + PW'(1);
        case ({push[n], pop[n]})
          2'b10:   cnt <= cnt + LW'(1);
          2'b01:   cnt <= cnt - LW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Entry storage; contents are only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
      if (push[n]) mem[wr_ptr] <= req_entry[n];
    end
  end

  // Per-bank round-robin grant between the two FIFO heads.
  always_comb begin
    gnt_a    = 2'b00;
    gnt_b    = 2'b00;
    gnt_a[0] = cand_a[0] && (!cand_a[1] || !rr_a);
    gnt_a[1] = cand_a[1] && (!cand_a[0] ||  rr_a);
    gnt_b[0] = cand_b[0] && (!cand_b[1] || !rr_b);
    gnt_b[1] = cand_b[1] && (!cand_b[0] ||  rr_b);
    win_a    = gnt_a[1] ? head[1] : head[0];
    win_b    = gnt_b[1] ? head[1] : head[0];
  end

  assign pop = gnt_a | gnt_b;

  // Registered write ports and round-robin pointers; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_A   <= 1'b0;
      wr_addr_A <= '0;
      wr_data_A <= '0;
      wr_en_B   <= 1'b0;
      wr_addr_B <= '0;
      wr_data_B <= '0;
      rr_a      <= 1'b0;
      rr_b      <= 1'b0;
    end else begin
      wr_en_A <= |gnt_a;
      wr_en_B <= |gnt_b;
      if (|gnt_a) begin
        wr_addr_A <= win_a.addr;
        wr_data_A <= win_a.data;
      end
      if (|gnt_b) begin
        wr_addr_B <= win_b.addr;
        wr_data_B <= win_b.data;
      end
      if (&cand_a) rr_a <= !rr_a;
      if (&cand_b) rr_b <= !rr_b;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed write schedules.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NC    = 16;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          c1_req_valid, c1_req_ready, c1_req_bank;
  logic [AW-1:0] c1_req_addr;
  logic [DW-1:0] c1_req_data;
  logic          c2_req_valid, c2_req_ready, c2_req_bank;
  logic [AW-1:0] c2_req_addr;
  logic [DW-1:0] c2_req_data;
  logic          wr_en_A, wr_en_B;
  logic [AW-1:0] wr_addr_A, wr_addr_B;
  logic [DW-1:0] wr_data_A, wr_data_B;
  logic [2:0]    c1_level, c2_level;

  req_t q1[$];
  req_t q2[$];
  wr_t  exp_a [NC];
  wr_t  exp_b [NC];
  int   lv1 [NC];
  int   lv2 [NC];
  logic rd1 [NC];
  logic rd2 [NC];
  int   checks   = 0;
  int   failures = 0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .c1_req_valid (c1_req_valid),
    .c1_req_ready (c1_req_ready),
    .c1_req_bank  (c1_req_bank),
    .c1_req_addr  (c1_req_addr),
    .c1_req_data  (c1_req_data),
    .c2_req_valid (c2_req_valid),
    .c2_req_ready (c2_req_ready),
    .c2_req_bank  (c2_req_bank),
    .c2_req_addr  (c2_req_addr),
    .c2_req_data  (c2_req_data),
    .wr_en_A      (wr_en_A),
    .wr_addr_A    (wr_addr_A),
    .wr_data_A    (wr_data_A),
    .wr_en_B      (wr_en_B),
    .wr_addr_B    (wr_addr_B),
    .wr_data_B    (wr_data_B),
    .c1_level     (c1_level),
    .c2_level     (c2_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic req_t rq(input logic bank, input int addr, input logic [DW-1:0] data);
    req_t r;
    r.bank = bank;
    r.addr = AW'(addr);
    r.data = data;
    return r;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < int'(NC); i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
  endtask

  // Expected write on a bank, visible in the cycle after edge 'cyc' of a run.
  task automatic expect_wr(input logic bank, input int cyc, input int addr, input logic [DW-1:0] data);
    wr_t w;
    w.en   = 1'b1;
    w.addr = AW'(addr);
    w.data = data;
    if (bank) exp_b[cyc] = w;
    else      exp_a[cyc] = w;
  endtask

  // Drives both request queues (held until accepted) and checks both write ports every cycle.
  task automatic run(input string name, input int n);
    logic f1, f2;
    for (int c = 0; c < n; c++) begin
      c1_req_valid = (q1.size() > 0);
      if (q1.size() > 0) begin
        c1_req_bank = q1[0].bank;
        c1_req_addr = q1[0].addr;
        c1_req_data = q1[0].data;
      end
      c2_req_valid = (q2.size() > 0);
      if (q2.size() > 0) begin
        c2_req_bank = q2[0].bank;
        c2_req_addr = q2[0].addr;
        c2_req_data = q2[0].data;
      end
      #1;
      f1 = c1_req_valid && c1_req_ready;
      f2 = c2_req_valid && c2_req_ready;
      @(negedge clk);
      if (f1) q1.delete(0);
      if (f2) q2.delete(0);
      lv1[c] = int'(c1_level);
      lv2[c] = int'(c2_level);
      rd1[c] = c1_req_ready;
      rd2[c] = c2_req_ready;
      check($sformatf("%s A_en c%0d", name, c), 64'(wr_en_A), 64'(exp_a[c].en));
      if (exp_a[c].en) begin
        check($sformatf("%s A_addr c%0d", name, c), 64'(wr_addr_A), 64'(exp_a[c].addr));
        check($sformatf("%s A_data c%0d", name, c), 64'(wr_data_A), 64'(exp_a[c].data));
      end
      check($sformatf("%s B_en c%0d", name, c), 64'(wr_en_B), 64'(exp_b[c].en));
      if (exp_b[c].en) begin
        check($sformatf("%s B_addr c%0d", name, c), 64'(wr_addr_B), 64'(exp_b[c].addr));
        check($sformatf("%s B_data c%0d", name, c), 64'(wr_data_B), 64'(exp_b[c].data));
      end
    end
    c1_req_valid = 1'b0;
    c2_req_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    c1_req_valid = 1'b1;
    c1_req_bank  = 1'b0;
    c1_req_addr  = AW'(9);
    c1_req_data  = 32'h99;
    c2_req_valid = 1'b0;
    c2_req_bank  = 1'b0;
    c2_req_addr  = '0;
    c2_req_data  = '0;

    // Reset held with a pending request: nothing accepted, nothing written.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst ready1 c%0d", i), 64'(c1_req_ready), 64'(0));
      check($sformatf("rst ready2 c%0d", i), 64'(c2_req_ready), 64'(0));
      check($sformatf("rst A_en c%0d", i), 64'(wr_en_A), 64'(0));
      check($sformatf("rst B_en c%0d", i), 64'(wr_en_B), 64'(0));
      check($sformatf("rst lvl1 c%0d", i), 64'(c1_level), 64'(0));
      check($sformatf("rst lvl2 c%0d", i), 64'(c2_level), 64'(0));
    end
    check("rst A_addr", 64'(wr_addr_A), 64'(0));
    check("rst A_data", 64'(wr_data_A), 64'(0));
    check("rst B_addr", 64'(wr_addr_B), 64'(0));
    check("rst B_data", 64'(wr_data_B), 64'(0));
    c1_req_valid = 1'b0;
    rst          = 1'b0;
    #1;
    check("post_rst ready1", 64'(c1_req_ready), 64'(1));
    check("post_rst ready2", 64'(c2_req_ready), 64'(1));

    // Single write: two-edge latency, one-cycle pulse, idle bank holds addr/data.
    clear_exp();
    q1.push_back(rq(1'b0, 5, 32'hDEADBEEF));
    expect_wr(1'b0, 1, 5, 32'hDEADBEEF);
    run("single", 3);
    check("single lvl1 c0", 64'(lv1[0]), 64'(1));
    check("single lvl1 c1", 64'(lv1[1]), 64'(0));
    check("single hold addr", 64'(wr_addr_A), 64'(5));
    check("single hold data", 64'(wr_data_A), 64'(32'hDEADBEEF));

    // Both cores stream to bank A: grants alternate starting with core 1.
    clear_exp();
    for (int i = 0; i < 4; i++) begin
      q1.push_back(rq(1'b0, 16 + i, 32'h10 + 32'(i)));
      q2.push_back(rq(1'b0, i, 32'h20 + 32'(i)));
      expect_wr(1'b0, 1 + 2 * i, 16 + i, 32'h10 + 32'(i));
      expect_wr(1'b0, 2 + 2 * i, i, 32'h20 + 32'(i));
    end
    run("contA", 10);

    // Core 1 on A and core 2 on B proceed together.
    clear_exp();
    for (int i = 0; i < 3; i++) begin
      q1.push_back(rq(1'b0, 8 + i, 32'h30 + 32'(i)));
      q2.push_back(rq(1'b1, 24 + i, 32'h40 + 32'(i)));
      expect_wr(1'b0, 1 + i, 8 + i, 32'h30 + 32'(i));
      expect_wr(1'b1, 1 + i, 24 + i, 32'h40 + 32'(i));
    end
    run("par", 5);

    // Bank A pointer was left on core 2 by the odd number of contended grants above.
    clear_exp();
    q1.push_back(rq(1'b0, 1, 32'h50));
    q2.push_back(rq(1'b0, 2, 32'h60));
    expect_wr(1'b0, 1, 2, 32'h60);
    expect_wr(1'b0, 2, 1, 32'h50);
    run("rrA", 4);

    // Core 1 queues B writes then A writes while core 2 floods bank B.
    clear_exp();
    for (int i = 0; i < 5; i++) q1.push_back(rq(1'b1, 1 + i, 32'h71 + 32'(i)));
    for (int i = 0; i < 3; i++) q1.push_back(rq(1'b0, 6 + i, 32'h76 + 32'(i)));
    for (int i = 0; i < 6; i++) q2.push_back(rq(1'b1, 16 + i, 32'h80 + 32'(i)));
    for (int i = 0; i < 5; i++) expect_wr(1'b1, 1 + 2 * i, 1 + i, 32'h71 + 32'(i));
    for (int i = 0; i < 4; i++) expect_wr(1'b1, 2 + 2 * i, 16 + i, 32'h80 + 32'(i));
    expect_wr(1'b1, 10, 20, 32'h84);
    expect_wr(1'b1, 11, 21, 32'h85);
    for (int i = 0; i < 3; i++) expect_wr(1'b0, 10 + i, 6 + i, 32'h76 + 32'(i));
    run("hol", 14);
    check("hol lvl1 c6", 64'(lv1[6]), 64'(4));
    check("hol ready1 c6", 64'(rd1[6]), 64'(0));
    check("hol lvl1 c7", 64'(lv1[7]), 64'(3));
    check("hol ready1 c7", 64'(rd1[7]), 64'(1));
    check("hol lvl1 c8", 64'(lv1[8]), 64'(4));
    check("hol lvl2 c5", 64'(lv2[5]), 64'(4));
    check("hol ready2 c5", 64'(rd2[5]), 64'(0));
    check("hol lvl1 c13", 64'(lv1[13]), 64'(0));

    // Mid-stream reset discards queued entries and suppresses any pending pulse.
    clear_exp();
    for (int i = 0; i < 3; i++) begin
      q1.push_back(rq(1'b1, 9 + i, 32'h91 + 32'(i)));
      q2.push_back(rq(1'b1, 25 + i, 32'hA1 + 32'(i)));
    end
    expect_wr(1'b1, 1, 25, 32'hA1);
    expect_wr(1'b1, 2, 9, 32'h91);
    run("pre_rst", 3);
    check("pre_rst lvl1", 64'(lv1[2]), 64'(2));
    check("pre_rst lvl2", 64'(lv2[2]), 64'(2));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst A_en", 64'(wr_en_A), 64'(0));
    check("mid_rst B_en", 64'(wr_en_B), 64'(0));
    check("mid_rst lvl1", 64'(c1_level), 64'(0));
    check("mid_rst lvl2", 64'(c2_level), 64'(0));
    check("mid_rst ready1", 64'(c1_req_ready), 64'(0));
    check("mid_rst B_addr", 64'(wr_addr_B), 64'(0));
    check("mid_rst B_data", 64'(wr_data_B), 64'(0));
    rst = 1'b0;
    #1;
    check("mid_rst release ready1", 64'(c1_req_ready), 64'(1));
    check("mid_rst release ready2", 64'(c2_req_ready), 64'(1));
    @(negedge clk);
    check("after_rst A_en", 64'(wr_en_A), 64'(0));
    check("after_rst B_en", 64'(wr_en_B), 64'(0));
    check("after_rst lvl1", 64'(c1_level), 64'(0));
    check("after_rst lvl2", 64'(c2_level), 64'(0));
    clear_exp();
    q1.push_back(rq(1'b0, 7, 32'h0BADF00D));
    expect_wr(1'b0, 1, 7, 32'h0BADF00D);
    run("post_rst", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
